sg110_framer: RTL and testbench

SG110_FRAMER -- requirements
Module: sg110_framer

---
 rtl/sg110_framer.sv | 103 ++++++++++
 tb/tb_sg110_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sg110_framer.sv
// Serial framer: each accepted word becomes preamble 1,1,0 followed by the pair 0,d per
// payload bit (MSB first). Because every payload bit is escaped by a leading 0, the
// pattern 1,1,0 can only occur at a preamble.
module sg110_framer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              sof,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Handshake: a word transfers on a rising edge where din_valid and din_ready are both 1.
  // din_ready depends only on registered state, never on din_valid.
  state_t            state;
  logic [1:0]        pcnt;
  logic [BW-1:0]     bcnt;
  logic              phase;
  logic [DATA_W-1:0] shreg;
  logic              last_data;
  logic              hs;

  // The state tracks what dout is carrying in the current cycle.
  assign last_data = (state == DATA) && phase && (bcnt == BW'(DATA_W - 1));
  assign din_ready = (state == IDLE) || last_data;
  assign hs        = din_valid && din_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pcnt  <= 2'd0;
      bcnt  <= '0;
      phase <= 1'b0;
      shreg <= '0;
      dout  <= 1'b0;
      sof   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sof <= 1'b0;
      if (hs) begin
        state <= PRE;
        pcnt  <= 2'd0;
        shreg <= din;
        dout  <= 1'b1;
        sof   <= 1'b1;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dout <= 1'b0;
            busy <= 1'b0;
          end
          PRE: begin
            if (pcnt == 2'd2) begin
              state <= DATA;
              bcnt  <= '0;
              phase <= 1'b0;
              dout  <= 1'b0;
            end else begin
              pcnt <= pcnt + 2'd1;
              dout <= (pcnt == 2'd0);
            end
          end
          DATA: begin
            if (!phase) begin
              phase <= 1'b1;
              dout  <= shreg[DATA_W-1];
            end else if (last_data) begin
              state <= IDLE;
              dout  <= 1'b0;
              busy  <= 1'b0;
            end else begin
              phase <= 1'b0;
              bcnt  <= bcnt + 1'b1;
              shreg <= shreg << 1;
              dout  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            dout  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sg110_framer.sv
// Bench for sg110_framer: a frame-level reference model (queue of upcoming line bits)
// plus a 1,1,0 detector and payload decoder on the serial output.
module tb_sg110_framer;

  localparam int DATA_W = 8;
  localparam int FLEN   = 3 + 2 * DATA_W;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              dout;
  logic              sof;
  logic              busy;
  logic [1:0]        dbg_state;

  sg110_framer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .sof       (sof),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: entries {third_preamble_bit, busy, sof, dout} still to appear on
  // the line after the current cycle. The framer is ready exactly when nothing is pending.
  logic [3:0]        exp_q[$];
  logic [3:0]        cur = 4'b0;
  logic [DATA_W-1:0] acc_q[$];

  function automatic logic [3:0] exp_vec();
    // {dout, sof, busy, din_ready}
    return {cur[0], cur[1], cur[2], (exp_q.size() == 0)};
  endfunction

  task automatic push_frame(input logic [DATA_W-1:0] d);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1100);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back(4'b0100);
      exp_q.push_back({3'b010, d[i]});
    end
  endtask

  // driver: apply inputs for one cycle, advance the model, return at the sampling edge
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r, output logic acc);
    din_valid = v;
    din       = d;
    reset     = r;
    acc       = 1'b0;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      cur = 4'b0;
    end else begin
      if (v && exp_q.size() == 0) begin
        acc = 1'b1;
        push_frame(d);
      end
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = 4'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic a;
    cyc(1'b1, 8'h5A, 1'b1, a);
    cyc(1'b0, 8'h00, 1'b1, a);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if ({dout, sof, busy, din_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset cyc %0d: {dout,sof,busy,rdy} got %b want 0001", i, {dout, sof, busy, din_ready});
      end
      cyc(1'b0, DATA_W'($urandom), 1'b0, a);
    end
  endtask

  task automatic test_single();
    logic a;
    logic [FLEN-1:0] a5_line = 19'b110_0100010000010001;
    cyc(1'b1, 8'hA5, 1'b0, a);
    for (int i = 0; i < FLEN + 3; i++) begin
      if (i > 0) cyc(1'b0, DATA_W'($urandom), 1'b0, a);
      vectors++;
      if ({dout, sof, busy, din_ready} !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc %0d: got %b want %b", i, {dout, sof, busy, din_ready}, exp_vec());
      end
      if (i < FLEN) begin
        vectors++;
        if (dout !== a5_line[FLEN-1-i] || sof !== (i == 0)) begin
          miscompares++;
          $display("FAIL single_a5 bit %0d: dout/sof got %b%b want %b%b", i, dout, sof,
                   a5_line[FLEN-1-i], (i == 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    int n_acc = 0;
    int busy_cnt = 0;
    int sof_cnt = 0;
    int sof_first = -1;
    int sof_last = -1;
    for (int c = 0; c < 45; c++) begin
      cyc(n_acc < 2, (n_acc == 0) ? 8'hFF : 8'h00, 1'b0, a);
      if (a) n_acc++;
      vectors++;
      if ({dout, sof, busy, din_ready} !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b cyc %0d: got %b want %b", c, {dout, sof, busy, din_ready}, exp_vec());
      end
      if (busy === 1'b1) busy_cnt++;
      if (sof === 1'b1) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = c;
        sof_last = c;
      end
    end
    vectors++;
    if (busy_cnt != 2 * FLEN || sof_cnt != 2 || sof_last - sof_first != FLEN) begin
      miscompares++;
      $display("FAIL b2b_totals: busy %0d sofs %0d gap %0d want %0d 2 %0d", busy_cnt, sof_cnt,
               sof_last - sof_first, 2 * FLEN, FLEN);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [FLEN-1:0] line = '0;
    logic [FLEN-1:0] want = 19'b110_0000000000000001;
    cyc(1'b1, 8'hC3, 1'b0, a);
    for (int i = 2; i <= 7; i++) cyc(1'b0, 8'h00, 1'b0, a);
    cyc(1'b1, 8'h7E, 1'b1, a);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({dout, sof, busy, din_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got %b want 0001", i, {dout, sof, busy, din_ready});
      end
      cyc(1'b0, 8'h00, 1'b0, a);
    end
    cyc(1'b1, 8'h01, 1'b0, a);
    for (int i = 0; i < FLEN + 2; i++) begin
      if (i > 0) cyc(1'b0, 8'hFF, 1'b0, a);
      if (i < FLEN) line = {line[FLEN-2:0], dout};
      vectors++;
      if ({dout, sof, busy, din_ready} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_frame cyc %0d: got %b want %b", i, {dout, sof, busy, din_ready}, exp_vec());
      end
    end
    vectors++;
    if (line !== want) begin
      miscompares++;
      $display("FAIL reset_mid_line: got %b want %b", line, want);
    end
  endtask

  task automatic test_random();
    logic a;
    logic v;
    logic [DATA_W-1:0] d;
    logic [2:0] hist = 3'b000;
    logic det;
    logic collecting = 1'b0;
    int k = 0;
    logic [DATA_W-1:0] word = '0;
    int frames = 0;
    int cycles = 0;
    acc_q.delete();
    while (cycles < 80000 && (frames < 2500 || exp_q.size() != 0 || collecting)) begin
      v = (frames < 2500) && ($urandom_range(0, 3) != 0);
      d = DATA_W'($urandom);
      cyc(v, d, 1'b0, a);
      cycles++;
      if (a) begin
        acc_q.push_back(d);
        frames++;
      end
      vectors++;
      if ({dout, sof, busy, din_ready} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b want %b", cycles, {dout, sof, busy, din_ready}, exp_vec());
      end
      hist = {hist[1:0], dout};
      if (collecting) begin
        k++;
        if (k % 2 == 0) word = (word << 1) | DATA_W'(dout);
        if (k == 2 * DATA_W) begin
          collecting = 1'b0;
          vectors++;
          if (acc_q.size() == 0) begin
            miscompares++;
            $display("FAIL random_decode: decoded %h with no accepted word pending", word);
          end else if (word !== acc_q[0]) begin
            miscompares++;
            $display("FAIL random_decode: got %h want %h", word, acc_q[0]);
            void'(acc_q.pop_front());
          end else begin
            void'(acc_q.pop_front());
          end
        end
      end
      det = (hist == 3'b110);
      vectors++;
      if (det !== cur[3]) begin
        miscompares++;
        $display("FAIL random_detect cyc %0d: detector %b want %b", cycles, det, cur[3]);
      end
      if (det) begin
        collecting = 1'b1;
        k = 0;
        word = '0;
      end
    end
    vectors++;
    if (cycles >= 80000 || frames != 2500 || acc_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_end: cycles %0d frames %0d undecoded %0d want frames 2500 undecoded 0",
               cycles, frames, acc_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
